// File: rtl/conv_encoder_k3_pkg.sv
// Shared constants, types and helpers for the K=3 rate-1/2 convolutional encoder.
// Also carries the trellis constants the Viterbi decoder's branch-metric unit relies on.
package conv_encoder_k3_pkg;

  localparam int unsigned K          = 3;
  localparam int unsigned TAIL_LEN   = K - 1;
  localparam int unsigned SR_W       = K - 1;
  localparam int unsigned SYM_W      = 2;
  localparam int unsigned TAIL_CNT_W = $clog2(TAIL_LEN);

  // Generator taps ordered {current bit, sr[1], sr[0]}: octal 7 and octal 5.
  localparam logic [K-1:0] G0_DEFAULT = 3'b111;
  localparam logic [K-1:0] G1_DEFAULT = 3'b101;

  // Symbol bit positions, shared with the decoder's branch-metric and select paths.
  localparam int unsigned SYM_G0_BIT = 1;
  localparam int unsigned SYM_G1_BIT = 0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TAIL = 1'b1
  } enc_state_t;

  typedef struct packed {
    logic [SYM_W-1:0] sym;
    logic             last;
    logic             tail;
  } sym_beat_t;

  // Expected code symbol for input bit b against shift-register contents sr.
  function automatic logic [SYM_W-1:0] branch_sym(input logic         b,
                                                  input logic [SR_W-1:0] sr,
                                                  input logic [K-1:0]    g0,
                                                  input logic [K-1:0]    g1);
    logic [SYM_W-1:0] s;
    s             = '0;
    s[SYM_G0_BIT] = ^(g0 & {b, sr});
    s[SYM_G1_BIT] = ^(g1 & {b, sr});
    return s;
  endfunction

endpackage

// File: rtl/conv_encoder_k3_if.sv
// Information-bit input stream and code-symbol output stream of the K=3 encoder.
// slave is the encoder's view; master is the upstream/downstream environment's view.
interface conv_encoder_k3_if import conv_encoder_k3_pkg::*; ();

  logic             in_valid;
  logic             in_ready;
  logic             in_bit;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [SYM_W-1:0] out_sym;
  logic             out_last;
  logic             out_tail;
  logic             busy;

  modport slave (
    input  in_valid, in_bit, in_last, out_ready,
    output in_ready, out_valid, out_sym, out_last, out_tail, busy
  );

  modport master (
    output in_valid, in_bit, in_last, out_ready,
    input  in_ready, out_valid, out_sym, out_last, out_tail, busy
  );

endinterface

// File: rtl/conv_branch_sym.sv
// Combinational branch-symbol generator: {b, sr} -> {g0, g1}.
// Reusable by the decoder for expected-symbol generation on each trellis branch.
module conv_branch_sym
  import conv_encoder_k3_pkg::*;
#(
  parameter logic [K-1:0] G0 = G0_DEFAULT,
  parameter logic [K-1:0] G1 = G1_DEFAULT
) (
  input  logic            b,
  input  logic [SR_W-1:0] sr,
  output logic [SYM_W-1:0] sym_c
);

  always_comb begin
    sym_c = branch_sym(b, sr, G0, G1);
  end

endmodule

// File: rtl/conv_encoder_k3.sv
// Rate-1/2, K=3 convolutional encoder with a single registered output slot.
// Optional zero-tail frame termination when CONV_ENC_TAIL_EN is defined.
module conv_encoder_k3
  import conv_encoder_k3_pkg::*;
#(
  parameter logic [K-1:0] G0 = G0_DEFAULT,
  parameter logic [K-1:0] G1 = G1_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  conv_encoder_k3_if.slave  bus
);

  logic             valid_q, valid_d;
  sym_beat_t        beat_q, beat_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic             slot_free;
  logic             in_ready_c;
  logic             enc_bit;
  logic [SYM_W-1:0] enc_sym;

`ifdef CONV_ENC_TAIL_EN
  enc_state_t              state_q, state_d;
  logic [TAIL_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    tail_done;

  assign tail_done = (cnt_q == TAIL_CNT_W'(TAIL_LEN - 1));
  // Tail bits are always zero; the information bit only feeds the encoder in RUN.
  assign enc_bit   = (state_q == ST_TAIL) ? 1'b0 : bus.in_bit;
`else
  assign enc_bit   = bus.in_bit;
`endif

  assign slot_free = !valid_q || bus.out_ready;

  conv_branch_sym #(
    .G0 (G0),
    .G1 (G1)
  ) u_branch_sym (
    .b     (enc_bit),
    .sr    (sr_q),
    .sym_c (enc_sym)
  );

  // State, shift register and output slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      beat_q  <= '0;
      sr_q    <= '0;
`ifdef CONV_ENC_TAIL_EN
      state_q <= ST_RUN;
      cnt_q   <= '0;
`endif
    end else begin
      valid_q <= valid_d;
      beat_q  <= beat_d;
      sr_q    <= sr_d;
`ifdef CONV_ENC_TAIL_EN
      state_q <= state_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next-state, slot load/drain and input acceptance.
  always_comb begin
    valid_d    = valid_q;
    beat_d     = beat_q;
    sr_d       = sr_q;
    in_ready_c = 1'b0;
`ifdef CONV_ENC_TAIL_EN
    state_d    = state_q;
    cnt_d      = cnt_q;
`endif

    // A drain clears the slot unless a load below refills it in the same cycle.
    if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end

`ifdef CONV_ENC_TAIL_EN
    case (state_q)
      ST_RUN: begin
        in_ready_c = slot_free;
        if (bus.in_valid && slot_free) begin
          valid_d = 1'b1;
          beat_d  = '{sym: enc_sym, last: 1'b0, tail: 1'b0};
          sr_d    = {bus.in_bit, sr_q[SR_W-1:1]};
          if (bus.in_last) begin
            state_d = ST_TAIL;
            cnt_d   = '0;
          end
        end
      end
      ST_TAIL: begin
        if (slot_free) begin
          valid_d = 1'b1;
          beat_d  = '{sym: enc_sym, last: tail_done, tail: 1'b1};
          sr_d    = {1'b0, sr_q[SR_W-1:1]};
          if (tail_done) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + TAIL_CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
`else
    in_ready_c = slot_free;
    if (bus.in_valid && slot_free) begin
      valid_d = 1'b1;
      beat_d  = '{sym: enc_sym, last: bus.in_last, tail: 1'b0};
      // Truncated trellis: the next frame starts from state 00.
      sr_d    = bus.in_last ? '0 : {bus.in_bit, sr_q[SR_W-1:1]};
    end
`endif
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = valid_q;
  assign bus.out_sym   = beat_q.sym;
  assign bus.out_last  = beat_q.last;
  assign bus.out_tail  = beat_q.tail;
`ifdef CONV_ENC_TAIL_EN
  assign bus.busy      = valid_q || (state_q == ST_TAIL);
`else
  assign bus.busy      = valid_q;
`endif

endmodule
